// File: rtl/dmi_reg_responder.sv
// DMI target answering read/write/nop requests from a local register file.
// Reg 0 is a read-only ID; one transaction in flight, fixed response latency.
module dmi_reg_responder #(
  parameter int          data_width_p  = 32,
  parameter int          addr_width_p  = 7,
  parameter int          num_regs_p    = 16,
  parameter int          rsp_latency_p = 2,
  parameter logic [31:0] id_p          = 32'h1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dmi_rst_n,
  input  logic                    dmi_req_valid,
  output logic                    dmi_req_ready,
  input  logic [addr_width_p-1:0] dmi_req_addr,
  input  logic [1:0]              dmi_req_op,
  input  logic [data_width_p-1:0] dmi_req_data,
  output logic                    dmi_rsp_valid,
  input  logic                    dmi_rsp_ready,
  output logic [data_width_p-1:0] dmi_rsp_data,
  output logic [1:0]              dmi_rsp_resp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] RESP_OK     = 2'd0;
  localparam logic [1:0] RESP_FAILED = 2'd2;

  localparam int idx_w_c = $clog2(num_regs_p);
  localparam int cnt_w_c = (rsp_latency_p > 0) ? $clog2(rsp_latency_p + 1) : 1;

  localparam logic [cnt_w_c-1:0]      cnt_load_c =
    (rsp_latency_p > 0) ? cnt_w_c'(rsp_latency_p - 1) : '0;
  localparam logic [addr_width_p:0]   num_regs_c = (addr_width_p + 1)'(num_regs_p);
  localparam logic [data_width_p-1:0] id_c       = data_width_p'(id_p);

  logic [1:0]              state_q;
  logic [cnt_w_c-1:0]      cnt_q;
  logic [data_width_p-1:0] regs_q [num_regs_p];
  logic [data_width_p-1:0] rsp_data_q;
  logic [1:0]              rsp_resp_q;

  logic                    accept;
  logic                    in_range;
  logic [idx_w_c-1:0]      idx;
  logic [data_width_p-1:0] rd_data_d;
  logic [1:0]              resp_d;
  logic                    wr_en;

  // While the soft reset is held, ready stays high but nothing is taken.
  assign dmi_req_ready = (state_q == IDLE);
  assign accept        = dmi_req_valid && dmi_req_ready && dmi_rst_n;
  assign dmi_rsp_valid = (state_q == RESP);
  assign dmi_rsp_data  = rsp_data_q;
  assign dmi_rsp_resp  = rsp_resp_q;

  assign in_range = ({1'b0, dmi_req_addr} < num_regs_c);
  assign idx      = dmi_req_addr[idx_w_c-1:0];

  always_comb begin
    rd_data_d = '0;
    resp_d    = RESP_OK;
    wr_en     = 1'b0;
    case (dmi_req_op)
      OP_NOP: begin
        resp_d = RESP_OK;
      end
      OP_READ: begin
        if (!in_range)                 resp_d    = RESP_FAILED;
        else if (dmi_req_addr == '0)   rd_data_d = id_c;
        else                           rd_data_d = regs_q[idx];
      end
      OP_WRITE: begin
        if (in_range && (dmi_req_addr != '0)) wr_en  = 1'b1;
        else                                  resp_d = RESP_FAILED;
      end
      default: begin
        resp_d = RESP_FAILED;
      end
    endcase
  end

  // The response is computed at accept time and held until the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_OK;
    end else if (!dmi_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= RESP_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rsp_data_q <= rd_data_d;
            rsp_resp_q <= resp_d;
            if (rsp_latency_p > 0) begin
              state_q <= WAIT;
              cnt_q   <= cnt_load_c;
            end else begin
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        RESP: begin
          if (dmi_rsp_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < num_regs_p; i++) regs_q[i] <= '0;
    end else if (!dmi_rst_n) begin
      for (int i = 0; i < num_regs_p; i++) regs_q[i] <= '0;
    end else if (accept && wr_en) begin
      regs_q[idx] <= dmi_req_data;
    end
  end

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Directed bench for dmi_reg_responder: one instance with latency 2, one with
// latency 0 for the back-to-back throughput case.
module tb_dmi_reg_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmi_rst_n;
  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;

  logic        b_dmi_rst_n;
  logic        b_req_valid, b_req_ready;
  logic [6:0]  b_req_addr;
  logic [1:0]  b_req_op;
  logic [31:0] b_req_data;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_data;
  logic [1:0]  b_rsp_resp;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmi_reg_responder #(
    .data_width_p(32), .addr_width_p(7), .num_regs_p(16),
    .rsp_latency_p(2), .id_p(32'h1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .dmi_rst_n(dmi_rst_n),
    .dmi_req_valid(req_valid), .dmi_req_ready(req_ready),
    .dmi_req_addr(req_addr), .dmi_req_op(req_op), .dmi_req_data(req_data),
    .dmi_rsp_valid(rsp_valid), .dmi_rsp_ready(rsp_ready),
    .dmi_rsp_data(rsp_data), .dmi_rsp_resp(rsp_resp)
  );

  dmi_reg_responder #(
    .data_width_p(32), .addr_width_p(7), .num_regs_p(16),
    .rsp_latency_p(0), .id_p(32'hA5A5_0001)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .dmi_rst_n(b_dmi_rst_n),
    .dmi_req_valid(b_req_valid), .dmi_req_ready(b_req_ready),
    .dmi_req_addr(b_req_addr), .dmi_req_op(b_req_op), .dmi_req_data(b_req_data),
    .dmi_rsp_valid(b_rsp_valid), .dmi_rsp_ready(b_rsp_ready),
    .dmi_rsp_data(b_rsp_data), .dmi_rsp_resp(b_rsp_resp)
  );

  // Issue one request on dut_a from a negedge with rsp_ready high; returns at
  // the negedge after the handshake. lat counts negedges from accept to valid.
  task automatic do_txn(input logic [1:0] op, input logic [6:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata,
                        output logic [1:0] resp, output int lat);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_data;
    resp  = rsp_resp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, rsp_valid, rsp_resp} !== 4'b1000 || rsp_data !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b resp=%0d data=%h expected 1/0/0/0",
               req_ready, rsp_valid, rsp_resp, rsp_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_id();
    int lat;
    logic ready_in_wait;
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'd0; req_data = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    ready_in_wait = req_ready;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (ready_in_wait !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_id_ready_low: got wait=%b resp=%b expected 0/0", ready_in_wait, req_ready);
    end
    checks++;
    if (lat !== 3) begin
      fails++;
      $display("[TB] FAIL read_id_latency: got %0d expected 3", lat);
    end
    checks++;
    if (rsp_data !== 32'h1 || rsp_resp !== 2'd0) begin
      fails++;
      $display("[TB] FAIL read_id_data: got %h/%0d expected 00000001/0", rsp_data, rsp_resp);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_id_return_idle: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r; int lat;
    do_txn(2'd2, 7'd5, 32'hDEAD_BEEF, d, r, lat);
    checks++;
    if (r !== 2'd0 || d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL write5: got %h/%0d expected 00000000/0", d, r);
    end
    do_txn(2'd1, 7'd5, 32'h0, d, r, lat);
    checks++;
    if (r !== 2'd0 || d !== 32'hDEAD_BEEF) begin
      fails++;
      $display("[TB] FAIL read5: got %h/%0d expected deadbeef/0", d, r);
    end
    do_txn(2'd2, 7'd0, 32'h5555_5555, d, r, lat);
    checks++;
    if (r !== 2'd2 || d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL write0: got %h/%0d expected 00000000/2", d, r);
    end
    do_txn(2'd1, 7'd0, 32'h0, d, r, lat);
    checks++;
    if (r !== 2'd0 || d !== 32'h1) begin
      fails++;
      $display("[TB] FAIL read0_after_write: got %h/%0d expected 00000001/0", d, r);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    do_txn(2'd2, 7'd15, 32'h0F0F_1234, d, r, lat);
    do_txn(2'd1, 7'd15, 32'h0, d, r, lat);
    checks++;
    if (r !== 2'd0 || d !== 32'h0F0F_1234) begin
      fails++;
      $display("[TB] FAIL read15: got %h/%0d expected 0f0f1234/0", d, r);
    end
    do_txn(2'd2, 7'd16, 32'hFFFF_FFFF, d, r, lat);
    checks++;
    if (r !== 2'd2 || d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL write16: got %h/%0d expected 00000000/2", d, r);
    end
    do_txn(2'd1, 7'd16, 32'h0, d, r, lat);
    checks++;
    if (r !== 2'd2 || d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL read16: got %h/%0d expected 00000000/2", d, r);
    end
    do_txn(2'd3, 7'd5, 32'h1111_1111, d, r, lat);
    checks++;
    if (r !== 2'd2 || d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL op3: got %h/%0d expected 00000000/2", d, r);
    end
    do_txn(2'd0, 7'd5, 32'h2222_2222, d, r, lat);
    checks++;
    if (r !== 2'd0 || d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL nop: got %h/%0d expected 00000000/0", d, r);
    end
    do_txn(2'd1, 7'd5, 32'h0, d, r, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++;
      $display("[TB] FAIL reg5_untouched: got %h expected deadbeef", d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; int lat;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'd5;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    // A write arriving while the response is stalled must be ignored.
    req_valid = 1'b1; req_op = 2'd2; req_addr = 7'd6; req_data = 32'h6666_6666;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_resp} !== 4'b1000 || rsp_data !== 32'hDEAD_BEEF) begin
        fails++;
        $display("[TB] FAIL backpressure_hold[%0d]: got valid=%b ready=%b resp=%0d data=%h expected 1/0/0/deadbeef",
                 i, rsp_valid, req_ready, rsp_resp, rsp_data);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL backpressure_release: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid);
    end
    do_txn(2'd1, 7'd6, 32'h0, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'd0) begin
      fails++;
      $display("[TB] FAIL reg6_ignored_write: got %h/%0d expected 00000000/0", d, r);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_valid;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_op = 2'd1; b_req_addr = 7'd0; b_req_data = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_valid = (i % 2 == 0);
      checks++;
      if (b_rsp_valid !== exp_valid) begin
        fails++;
        $display("[TB] FAIL lat0_valid[%0d]: got %b expected %b", i, b_rsp_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (b_rsp_data !== 32'hA5A5_0001 || b_rsp_resp !== 2'd0) begin
          fails++;
          $display("[TB] FAIL lat0_data[%0d]: got %h/%0d expected a5a50001/0", i, b_rsp_data, b_rsp_resp);
        end
      end
    end
    b_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_soft_reset();
    logic [31:0] d; logic [1:0] r; int lat; int seen;
    req_valid = 1'b1; req_op = 2'd2; req_addr = 7'd3; req_data = 32'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL soft_reset_in_wait: got ready=%b expected 0", req_ready);
    end
    dmi_rst_n = 1'b0;
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'd3;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL soft_reset_idle: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL soft_reset_no_accept: got ready=%b expected 1", req_ready);
    end
    dmi_rst_n = 1'b1;
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("[TB] FAIL soft_reset_no_response: got %0d responses expected 0", seen);
    end
    do_txn(2'd1, 7'd3, 32'h0, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'd0) begin
      fails++;
      $display("[TB] FAIL soft_reset_reg3: got %h/%0d expected 00000000/0", d, r);
    end
    do_txn(2'd1, 7'd5, 32'h0, d, r, lat);
    checks++;
    if (d !== 32'h0) begin
      fails++;
      $display("[TB] FAIL soft_reset_reg5: got %h expected 00000000", d);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'd0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL async_reset_setup: got valid=%b expected 1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'h0) begin
      fails++;
      $display("[TB] FAIL async_reset_immediate: got valid=%b ready=%b data=%h expected 0/1/0",
               rsp_valid, req_ready, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; dmi_rst_n = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_op = '0; req_data = '0; rsp_ready = 1'b1;
    b_dmi_rst_n = 1'b1;
    b_req_valid = 1'b0; b_req_addr = '0; b_req_op = '0; b_req_data = '0; b_rsp_ready = 1'b1;

    test_reset();
    test_read_id();
    test_write_read();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_soft_reset();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
